maze_move_ctrl: RTL
===================

MAZE_MOVE_CTRL -- requirements
Module: maze_move_ctrl

Interface
REQ-001 SHALL have parameter GRID_W, default 16, meaning maze width in cells (max 16).
REQ-002 SHALL have parameter GRID_H, default 16, meaning maze height in cells (max 16).
REQ-003 SHALL have parameters START_X/START_Y, default 0/0, meaning player reset cell.
REQ-004 SHALL have parameters GOAL_X/GOAL_Y, default 15/15, meaning goal cell.
REQ-005 SHALL have parameter MEM_TIMEOUT, default 15, meaning max cycles to wait for i_MemValid.
REQ-006 SHALL have port Clk, input, 1, meaning the single system clock (rising edge).
REQ-007 SHALL have port Rst, input, 1, meaning reset, asynchronous and active-low.
REQ-008 SHALL have port i_Keyboard, input, 4, meaning active-low buttons: [3] up, [2] down, [1] left, [0] right.
REQ-009 SHALL have port i_fDrawDone, input, 1, meaning a one-cycle pulse at the end of the frame draw.
REQ-010 SHALL have port o_MemRd, output, 1, meaning a one-cycle maze-ROM read strobe.
REQ-011 SHALL have port o_MemAddr, output, 8, meaning {targetY[3:0], targetX[3:0]}.
REQ-012 SHALL have port i_MemValid, input, 1, meaning the read data is valid this cycle.
REQ-013 SHALL have port i_MemWall, input, 1, meaning the target cell is a wall; sampled only with i_MemValid.
REQ-014 SHALL have ports o_PosX and o_PosY, outputs, 4 each, meaning the current player cell.
REQ-015 SHALL have port o_MoveCnt, output, 10, meaning accepted moves in binary, for FND display.
REQ-016 SHALL have port o_Win, output, 1, meaning the goal has been reached.
REQ-017 SHALL have port o_LED, output, 4, meaning the direction of the last accepted press (one-hot, active-high).

Function
REQ-018 SHALL decode a press as valid only when exactly one i_Keyboard bit is 0; 4'b1111 is idle, and any other value is invalid and ignored.
REQ-019 SHALL require an armed flag to accept a press: the flag is set when i_Keyboard==4'b1111 and cleared when a press is accepted, so each move requires a release.
REQ-020 SHALL implement the FSM states IDLE, WAIT_FRAME, CHECK, READ, WAIT_MEM, UPDATE and WIN.
REQ-021 SHALL, in IDLE with a valid, armed press, latch the direction, update o_LED, and go to WAIT_FRAME on the next cycle.
REQ-022 SHALL, in WAIT_FRAME, stay until i_fDrawDone==1 and then go to CHECK, so position never changes mid-frame.
REQ-023 SHALL, in CHECK, compute the target cell and return to IDLE without a read if the target is outside 0..GRID_W-1 / 0..GRID_H-1; otherwise it goes to READ.
REQ-024 SHALL, in READ, assert o_MemRd for exactly one cycle with o_MemAddr set to the target, then go to WAIT_MEM.
REQ-025 SHALL hold o_MemAddr stable from READ until leaving WAIT_MEM.
REQ-026 SHALL, in WAIT_MEM, go to UPDATE on i_MemValid with i_MemWall==0, and to IDLE on i_MemValid with i_MemWall==1.
REQ-027 SHALL go from WAIT_MEM to IDLE with no move after MEM_TIMEOUT cycles without i_MemValid.
REQ-028 SHALL, in UPDATE, load the target into o_PosX/o_PosY and increment o_MoveCnt (saturating at 999), then go to WIN if the new cell equals GOAL, else to IDLE.
REQ-029 SHALL hold WIN until reset, ignoring keys and i_fDrawDone, with o_Win=1 and o_MemRd=0.
REQ-030 SHALL ignore keyboard changes outside IDLE; the latched direction is used.
REQ-031 SHALL ignore an i_fDrawDone pulse that arrives outside WAIT_FRAME.
REQ-032 SHALL not check against GOAL in the same way when GOAL equals START; o_Win is set only via UPDATE.

Reset
REQ-033 SHALL, while Rst==0 (including mid-operation), force state=IDLE, o_PosX=START_X, o_PosY=START_Y, o_MoveCnt=0, o_Win=0, o_LED=0, o_MemRd=0, o_MemAddr=0 and armed=0.
REQ-034 SHALL, after release, begin accepting presses only after i_Keyboard==4'b1111 has been seen once.

Verification
REQ-035 SHALL cover this scenario: reset, keys 1111, then 1110 (right), then i_fDrawDone, then i_MemValid with i_MemWall=0 -> one o_MemRd with addr 8'h01, then Pos=(1,0), MoveCnt=1, o_LED=4'b0001.
REQ-036 SHALL cover this scenario: hold 1110 across two frames with no release -> only one move is accepted, and MoveCnt stays at 1.
REQ-037 SHALL cover this scenario: at (0,0), press up (0111) and give i_fDrawDone -> no o_MemRd, position unchanged, FSM returns to IDLE.
REQ-038 SHALL cover this scenario: press 1001 (two buttons) -> ignored; then press 1011 (down) with i_MemWall=1 -> position unchanged, MoveCnt unchanged.
REQ-039 SHALL cover this scenario: withhold i_MemValid for 16 cycles -> timeout back to IDLE; a later press still works.
REQ-040 SHALL cover this scenario: move into GOAL (15,15) -> o_Win=1, further presses are ignored, and an asserted Rst mid-WAIT_MEM returns all outputs to reset values immediately.

Source files
------------

// File: rtl/maze_move_ctrl_if.sv
// Maze-ROM read handshake between the move controller (master) and the maze memory (slave).
// The controller issues a single-cycle read strobe and then waits for valid/wall data.
interface maze_move_ctrl_if;
    logic       o_MemRd;
    logic [7:0] o_MemAddr;
    logic       i_MemValid;
    logic       i_MemWall;

    modport master (
        output o_MemRd,
        output o_MemAddr,
        input  i_MemValid,
        input  i_MemWall
    );

    modport slave (
        input  o_MemRd,
        input  o_MemAddr,
        output i_MemValid,
        output i_MemWall
    );
endinterface

// File: rtl/maze_move_ctrl.sv
// Player movement controller for a grid maze: debounced-by-release key presses are applied
// once per frame after a wall lookup in the maze ROM; reaching the goal latches a win.
module maze_move_ctrl #(
    parameter int GRID_W      = 16,
    parameter int GRID_H      = 16,
    parameter int START_X     = 0,
    parameter int START_Y     = 0,
    parameter int GOAL_X      = 15,
    parameter int GOAL_Y      = 15,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [3:0]              i_Keyboard,
    input  logic                    i_fDrawDone,
    maze_move_ctrl_if.master        mem,
    output logic [3:0]              o_PosX,
    output logic [3:0]              o_PosY,
    output logic [9:0]              o_MoveCnt,
    output logic                    o_Win,
    output logic [3:0]              o_LED
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_FRAME = 3'd1,
        ST_CHECK      = 3'd2,
        ST_READ       = 3'd3,
        ST_WAIT_MEM   = 3'd4,
        ST_UPDATE     = 3'd5,
        ST_WIN        = 3'd6
    } state_t;

    localparam logic [3:0] X_MAX     = 4'(GRID_W - 1);
    localparam logic [3:0] Y_MAX     = 4'(GRID_H - 1);
    localparam logic [3:0] X_START   = 4'(START_X);
    localparam logic [3:0] Y_START   = 4'(START_Y);
    localparam logic [7:0] GOAL_ADDR = {4'(GOAL_Y), 4'(GOAL_X)};
    localparam logic [7:0] TO_LAST   = 8'(MEM_TIMEOUT - 1);
    localparam logic [9:0] CNT_MAX   = 10'd999;

    state_t     state_r;
    state_t     state_s;
    logic       armed_r;
    logic [3:0] led_r;
    logic [3:0] pos_x_r;
    logic [3:0] pos_y_r;
    logic [9:0] move_cnt_r;
    logic       win_r;
    logic       mem_rd_r;
    logic [7:0] mem_addr_r;
    logic [7:0] to_cnt_r;

    logic       key_idle_s;
    logic       key_valid_s;
    logic       accept_s;
    logic [3:0] tgt_x_s;
    logic [3:0] tgt_y_s;
    logic       tgt_ok_s;

    // A press is valid when exactly one active-low button is down.
    function automatic logic is_single_press(input logic [3:0] keys);
        logic [3:0] down;
        down = ~keys;
        return (down != 4'b0000) && ((down & (down - 4'b0001)) == 4'b0000);
    endfunction

    assign key_idle_s  = (i_Keyboard == 4'b1111);
    assign key_valid_s = is_single_press(i_Keyboard);
    assign accept_s    = (state_r == ST_IDLE) && armed_r && key_valid_s;

    // Target cell from the latched direction; out-of-grid moves are flagged, not wrapped.
    always_comb begin
        tgt_x_s  = pos_x_r;
        tgt_y_s  = pos_y_r;
        tgt_ok_s = 1'b0;
        case (led_r)
            4'b1000: begin
                if (pos_y_r != 4'd0) begin
                    tgt_y_s  = pos_y_r - 4'd1;
                    tgt_ok_s = 1'b1;
                end else begin
                    tgt_ok_s = 1'b0;
                end
            end
            4'b0100: begin
                if (pos_y_r < Y_MAX) begin
                    tgt_y_s  = pos_y_r + 4'd1;
                    tgt_ok_s = 1'b1;
                end else begin
                    tgt_ok_s = 1'b0;
                end
            end
            4'b0010: begin
                if (pos_x_r != 4'd0) begin
                    tgt_x_s  = pos_x_r - 4'd1;
                    tgt_ok_s = 1'b1;
                end else begin
                    tgt_ok_s = 1'b0;
                end
            end
            4'b0001: begin
                if (pos_x_r < X_MAX) begin
                    tgt_x_s  = pos_x_r + 4'd1;
                    tgt_ok_s = 1'b1;
                end else begin
                    tgt_ok_s = 1'b0;
                end
            end
            default: begin
                tgt_ok_s = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_WAIT_FRAME;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT_FRAME: begin
                if (i_fDrawDone) begin
                    state_s = ST_CHECK;
                end else begin
                    state_s = ST_WAIT_FRAME;
                end
            end
            ST_CHECK: begin
                if (tgt_ok_s) begin
                    state_s = ST_READ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                state_s = ST_WAIT_MEM;
            end
            ST_WAIT_MEM: begin
                if (mem.i_MemValid) begin
                    if (mem.i_MemWall) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_UPDATE;
                    end
                end else if (to_cnt_r == TO_LAST) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT_MEM;
                end
            end
            ST_UPDATE: begin
                if (mem_addr_r == GOAL_ADDR) begin
                    state_s = ST_WIN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WIN: begin
                state_s = ST_WIN;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs; the read strobe is aligned with the READ state.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            armed_r    <= 1'b0;
            led_r      <= 4'b0000;
            pos_x_r    <= X_START;
            pos_y_r    <= Y_START;
            move_cnt_r <= 10'd0;
            win_r      <= 1'b0;
            mem_rd_r   <= 1'b0;
            mem_addr_r <= 8'h00;
            to_cnt_r   <= 8'd0;
        end else begin
            if (accept_s) begin
                armed_r <= 1'b0;
                led_r   <= ~i_Keyboard;
            end else if (key_idle_s) begin
                armed_r <= 1'b1;
            end

            mem_rd_r <= (state_s == ST_READ);
            win_r    <= (state_s == ST_WIN);

            // The address doubles as the target store and stays put until the next CHECK.
            if ((state_r == ST_CHECK) && tgt_ok_s) begin
                mem_addr_r <= {tgt_y_s, tgt_x_s};
            end

            if (state_r == ST_WAIT_MEM) begin
                to_cnt_r <= to_cnt_r + 8'd1;
            end else begin
                to_cnt_r <= 8'd0;
            end

            if (state_r == ST_UPDATE) begin
                pos_x_r <= mem_addr_r[3:0];
                pos_y_r <= mem_addr_r[7:4];
                if (move_cnt_r != CNT_MAX) begin
                    move_cnt_r <= move_cnt_r + 10'd1;
                end
            end
        end
    end

    assign mem.o_MemRd   = mem_rd_r;
    assign mem.o_MemAddr = mem_addr_r;
    assign o_PosX        = pos_x_r;
    assign o_PosY        = pos_y_r;
    assign o_MoveCnt     = move_cnt_r;
    assign o_Win         = win_r;
    assign o_LED         = led_r;

endmodule
